// File: rtl/ddr3_arb_pkg.sv
// Shared constants and types for the DDR3 round-robin arbiter.
// Command encodings match the DDR3 IP user interface.
package ddr3_arb_pkg;

  localparam int ADDR_W_DEF = 29;
  localparam int DATA_W_DEF = 256;
  localparam int MASK_W_DEF = 32;
  localparam int REQ_ID_W   = 1;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/ddr3_arb_tag_fifo.sv
// Owner-tag FIFO: remembers which requester issued each read.
// Push when full and pop when empty are ignored.
module ddr3_arb_tag_fifo
  import ddr3_arb_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  req_id_t       din_i,
  input  logic          pop_i,
  output req_id_t       dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  req_id_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Qualify requests and advance pointers / occupancy
  always_comb begin
    push_ok  = push_i & ~full_o;
    pop_ok   = pop_i & ~empty_o;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Tag storage; contents are only meaningful below the count
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ddr3_rr_arbiter.sv
// Two-requester round-robin arbiter in front of the DDR3 IP UI.
// Zero-latency issue; read data routed back by owner tag.
module ddr3_rr_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int MASK_WIDTH = MASK_W_DEF,
  parameter int TAG_DEPTH  = 16,
  localparam int CW = $clog2(TAG_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_calib_complete,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [MASK_WIDTH-1:0] m0_wmask,
  output logic                  m0_ack,
  output logic                  m0_rd_valid,
  output logic [DATA_WIDTH-1:0] m0_rd_data,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [MASK_WIDTH-1:0] m1_wmask,
  output logic                  m1_ack,
  output logic                  m1_rd_valid,
  output logic [DATA_WIDTH-1:0] m1_rd_data,
  output logic                  cmd_en,
  output logic [2:0]            cmd,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic                  cmd_ready,
  output logic                  wr_data_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [MASK_WIDTH-1:0] wr_data_mask,
  output logic                  wr_data_end,
  input  logic                  wr_data_rdy,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_valid,
  output logic [CW-1:0]         rd_outstanding,
  output logic                  tag_err
);

  logic prio_q, prio_d;
  logic elig0_c, elig1_c, gnt0_c, gnt1_c;
  logic issue_c, src_we_c, push_c, pop_c;
  logic full_c, empty_c;
  req_id_t tag_c;
  logic m0v_q, m0v_d, m1v_q, m1v_d;
  logic [DATA_WIDTH-1:0] m0d_q, m0d_d, m1d_q, m1d_d;
  logic tag_err_q, tag_err_d;

  ddr3_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tags (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .din_i   (req_id_t'(gnt1_c)),
    .pop_i   (pop_c),
    .dout_o  (tag_c),
    .count_o (rd_outstanding),
    .full_o  (full_c),
    .empty_o (empty_c)
  );

  // Eligibility and priority-ordered grant; reset masks all grants
  always_comb begin
    elig0_c = rst_n & init_calib_complete & cmd_ready & m0_req
            & (m0_we ? wr_data_rdy : ~full_c);
    elig1_c = rst_n & init_calib_complete & cmd_ready & m1_req
            & (m1_we ? wr_data_rdy : ~full_c);
    gnt0_c  = elig0_c & (~prio_q | ~elig1_c);
    gnt1_c  = elig1_c & (prio_q | ~elig0_c);
  end

  // Downstream command/data mux; idle cycles show m0's fields
  always_comb begin
    issue_c      = gnt0_c | gnt1_c;
    src_we_c     = gnt1_c ? m1_we : m0_we;
    push_c       = issue_c & ~src_we_c;
    m0_ack       = gnt0_c;
    m1_ack       = gnt1_c;
    cmd_en       = issue_c;
    cmd          = src_we_c ? CMD_WRITE : CMD_READ;
    addr         = gnt1_c ? m1_addr : m0_addr;
    wr_data      = gnt1_c ? m1_wdata : m0_wdata;
    wr_data_mask = gnt1_c ? m1_wmask : m0_wmask;
    wr_data_en   = issue_c & src_we_c;
    wr_data_end  = issue_c & src_we_c;
  end

  // Next priority, read-return routing and tag error
  always_comb begin
    prio_d    = issue_c ? ~gnt1_c : prio_q;
    pop_c     = rd_data_valid & ~empty_c;
    m0v_d     = pop_c & (tag_c == req_id_t'(0));
    m1v_d     = pop_c & (tag_c == req_id_t'(1));
    m0d_d     = m0v_d ? rd_data : m0d_q;
    m1d_d     = m1v_d ? rd_data : m1d_q;
    tag_err_d = tag_err_q | (rd_data_valid & empty_c);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= 1'b0;
      m0v_q     <= 1'b0;
      m1v_q     <= 1'b0;
      m0d_q     <= '0;
      m1d_q     <= '0;
      tag_err_q <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      m0v_q     <= m0v_d;
      m1v_q     <= m1v_d;
      m0d_q     <= m0d_d;
      m1d_q     <= m1d_d;
      tag_err_q <= tag_err_d;
    end
  end

  assign m0_rd_valid = m0v_q;
  assign m1_rd_valid = m1v_q;
  assign m0_rd_data  = m0d_q;
  assign m1_rd_data  = m1d_q;
  assign tag_err     = tag_err_q;

endmodule

// File: tb/tb_ddr3_rr_arbiter.sv
// Bench for ddr3_rr_arbiter: directed scenarios plus random traffic,
// checked against a queue-based reference model and read scoreboard.
module tb_ddr3_rr_arbiter;

  localparam int AW = 29;
  localparam int DW = 256;
  localparam int MW = 32;
  localparam int TD = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, calib, cmd_ready, wr_rdy, rdv;
  logic [DW-1:0] rdd;
  logic          req [2];
  logic          we [2];
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];
  logic [MW-1:0] wm [2];

  logic          m0_ack, m1_ack, m0_rd_valid, m1_rd_valid;
  logic [DW-1:0] m0_rd_data, m1_rd_data, wr_data;
  logic          cmd_en, wr_data_en, wr_data_end, tag_err;
  logic [2:0]    cmd;
  logic [AW-1:0] addr;
  logic [MW-1:0] wr_data_mask;
  logic [CW-1:0] rd_outstanding;

  ddr3_rr_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MASK_WIDTH (MW),
    .TAG_DEPTH  (TD)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (calib),
    .m0_req              (req[0]),
    .m0_we               (we[0]),
    .m0_addr             (ad[0]),
    .m0_wdata            (wd[0]),
    .m0_wmask            (wm[0]),
    .m0_ack              (m0_ack),
    .m0_rd_valid         (m0_rd_valid),
    .m0_rd_data          (m0_rd_data),
    .m1_req              (req[1]),
    .m1_we               (we[1]),
    .m1_addr             (ad[1]),
    .m1_wdata            (wd[1]),
    .m1_wmask            (wm[1]),
    .m1_ack              (m1_ack),
    .m1_rd_valid         (m1_rd_valid),
    .m1_rd_data          (m1_rd_data),
    .cmd_en              (cmd_en),
    .cmd                 (cmd),
    .addr                (addr),
    .cmd_ready           (cmd_ready),
    .wr_data_en          (wr_data_en),
    .wr_data             (wr_data),
    .wr_data_mask        (wr_data_mask),
    .wr_data_end         (wr_data_end),
    .wr_data_rdy         (wr_rdy),
    .rd_data             (rdd),
    .rd_data_valid       (rdv),
    .rd_outstanding      (rd_outstanding),
    .tag_err             (tag_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  bit            prio;
  bit            terr;
  bit            tags [$];
  bit            rq_id [$];
  logic [DW-1:0] rq_d [$];
  int            rq_due [$];
  logic          ack_s [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: arbitration from the rules, tags as a queue
  always @(negedge clk) begin : model
    int  g;
    int  s;
    bit  el [2];
    bit  t;
    ack_s[0] <= m0_ack;
    ack_s[1] <= m1_ack;
    if (!rst_n) begin
      prio = 1'b0;
      terr = 1'b0;
      tags.delete();
      rq_id.delete();
      rq_d.delete();
      rq_due.delete();
      chk("rst_cmd_en", cmd_en, 0);
      chk("rst_acks", {m0_ack, m1_ack}, 0);
      chk("rst_wr_en", {wr_data_en, wr_data_end}, 0);
      chk("rst_rd_valid", {m0_rd_valid, m1_rd_valid}, 0);
      chk("rst_rd_data0", m0_rd_data, 0);
      chk("rst_rd_data1", m1_rd_data, 0);
      chk("rst_outstanding", rd_outstanding, 0);
      chk("rst_tag_err", tag_err, 0);
    end else begin
      for (int i = 0; i < 2; i++)
        el[i] = req[i] && calib && cmd_ready &&
                (we[i] ? wr_rdy : (tags.size() < TD));
      g = -1;
      if (el[prio]) g = int'(prio);
      else if (el[!prio]) g = int'(!prio);
      s = (g < 0) ? 0 : g;
      chk("cmd_en", cmd_en, g >= 0);
      chk("m0_ack", m0_ack, g == 0);
      chk("m1_ack", m1_ack, g == 1);
      chk("wr_data_en", wr_data_en, g >= 0 && we[s]);
      chk("wr_data_end", wr_data_end, g >= 0 && we[s]);
      chk("addr", addr, ad[s]);
      chk("wr_data", wr_data, wd[s]);
      chk("wr_mask", wr_data_mask, wm[s]);
      if (g >= 0) chk("cmd", cmd, we[s] ? 3'b000 : 3'b001);
      chk("rd_outstanding", rd_outstanding, tags.size());
      chk("tag_err", tag_err, terr);
      if (rdv) begin
        if (tags.size() > 0) begin
          t = tags.pop_front();
          rq_id.push_back(t);
          rq_d.push_back(rdd);
          rq_due.push_back(cyc + 1);
        end else begin
          terr = 1'b1;
        end
      end
      if (g >= 0) begin
        prio = (g == 0);
        if (!we[s]) tags.push_back(g[0]);
      end
    end
  end

  // Read-return monitor: pops the scoreboard when DUT shows rd_valid
  always @(negedge clk) begin : mon
    bit            id;
    logic [DW-1:0] d;
    int            due;
    if (rst_n) begin
      chk("rd_onehot", m0_rd_valid & m1_rd_valid, 0);
      if (m0_rd_valid | m1_rd_valid) begin
        if (rq_id.size() == 0) begin
          chk("rd_unexpected", m0_rd_valid | m1_rd_valid, 0);
        end else begin
          id  = rq_id.pop_front();
          d   = rq_d.pop_front();
          due = rq_due.pop_front();
          chk("rd_owner", m1_rd_valid, id);
          chk("rd_data", id ? m1_rd_data : m0_rd_data, d);
          chk("rd_latency", cyc, due);
        end
      end else if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        chk("rd_missing", m0_rd_valid | m1_rd_valid, 1);
        void'(rq_id.pop_front());
        void'(rq_d.pop_front());
        void'(rq_due.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic newreq(input int i, input bit w);
    req[i] = 1'b1;
    we[i]  = w;
    ad[i]  = AW'($urandom);
    wd[i]  = rnd();
    wm[i]  = $urandom;
  endtask

  task automatic drain(input int n);
    req[0] = 1'b0;
    req[1] = 1'b0;
    for (int k = 0; k < n; k++) begin
      rdv = tags.size() > 0;
      rdd = rnd();
      step();
    end
    rdv = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [3:0] nib [4];

  initial begin
    nib = '{4'hA, 4'hB, 4'hC, 4'hD};
    rst_n = 1'b0; calib = 1'b0; cmd_ready = 1'b1; wr_rdy = 1'b1;
    rdv = 1'b0; rdd = '0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b1; we[i] = 1'b0; ad[i] = '0; wd[i] = '0; wm[i] = '0;
    end
    step(); step(); step();
    req[0] = 1'b0; req[1] = 1'b0;
    rst_n = 1'b1;
    calib = 1'b1;

    // Continuous reads from both, then patterned returns
    newreq(0, 0); newreq(1, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      for (int i = 0; i < 2; i++) if (ack_s[i]) newreq(i, 0);
    end
    req[0] = 1'b0; req[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rdv = 1'b1;
      rdd = {64{nib[k]}};
      step();
    end
    rdv = 1'b0;
    step();

    // Write stalled by wr_data_rdy
    newreq(0, 1);
    ad[0] = 29'h100; wd[0] = {64{4'h5}}; wm[0] = '0;
    wr_rdy = 1'b0;
    step(); step(); step();
    wr_rdy = 1'b1;
    step();
    req[0] = 1'b0;
    step();

    // Tag FIFO full: 5th read stalls, write still proceeds
    for (int k = 0; k < 4; k++) begin
      newreq(1, 0);
      step();
    end
    newreq(1, 0);
    step(); step();
    newreq(0, 1);
    step();
    req[0] = 1'b0;
    rdv = 1'b1; rdd = rnd();
    step();
    rdv = 1'b0;
    step();
    drain(8);

    // Calibration low for 100 cycles, then m0 first
    do_reset();
    calib = 1'b0;
    newreq(0, 0); newreq(1, 0);
    repeat (100) step();
    calib = 1'b1;
    step();
    for (int i = 0; i < 2; i++) if (ack_s[i]) newreq(i, 0);
    step();
    drain(8);

    // Return with empty FIFO sets sticky tag_err
    rdv = 1'b1; rdd = rnd();
    step();
    rdv = 1'b0;
    repeat (4) step();

    // Reset with reads outstanding
    for (int k = 0; k < 3; k++) begin
      newreq(k % 2, 0);
      step();
      req[k % 2] = 1'b0;
    end
    newreq(0, 0);
    rst_n = 1'b0;
    #1;
    chk("async_cmd_en", cmd_en, 0);
    chk("async_outstanding", rd_outstanding, 0);
    chk("async_tag_err", tag_err, 0);
    step(); step();
    req[0] = 1'b0;
    rst_n = 1'b1;
    newreq(1, 0);
    step();
    req[1] = 1'b0;
    rdv = 1'b1; rdd = rnd();
    step();
    rdv = 1'b0;
    step(); step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (ack_s[i] || !req[i]) begin
          if ($urandom % 3 != 0) newreq(i, 1'($urandom % 2));
          else req[i] = 1'b0;
        end
      end
      calib     = ($urandom % 16) != 0;
      cmd_ready = ($urandom % 4) != 0;
      wr_rdy    = ($urandom % 4) != 0;
      rdv       = (tags.size() > 0) && ($urandom % 3 == 0);
      rdd       = rnd();
      step();
    end
    calib = 1'b1;
    drain(10);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
